// File: rtl/hc112_pkg.sv
// Shared types and helpers for the HC112 dual JK flip-flop op scheduler.
package hc112_pkg;

  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_RESET   = 3'd1,
    OP_SET     = 3'd2,
    OP_TOGGLE  = 3'd3,
    OP_APRESET = 3'd4,
    OP_ACLEAR  = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE,
    ST_DONE
  } state_e;

  // {J,K} for a clocked op; async ops, HOLD and illegal codes leave J = K = 0
  function automatic logic [1:0] op_to_jk(input logic [2:0] op);
    case (op)
      OP_RESET:  return 2'b01;
      OP_SET:    return 2'b10;
      OP_TOGGLE: return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'(OP_ACLEAR));
  endfunction

endpackage

// File: rtl/hc112_rr_arb.sv
// Two-requester round-robin arbiter; grants are combinational, the
// last-served pointer only moves when a grant is actually taken.
module hc112_rr_arb (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic r_last;  // 0 = A served last, 1 = B served last

  assign o_gnt_a = i_en & i_req_a & (~i_req_b | r_last);
  assign o_gnt_b = i_en & i_req_b & (~i_req_a | ~r_last);

  // Remember who was served so the other side wins the next tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_last <= 1'b1;
    else if (o_gnt_a | o_gnt_b)  r_last <= o_gnt_b;
  end

endmodule

// File: rtl/hc112_op_sched.sv
// Sequences requested operations onto a shared dual JK flip-flop:
// J/K setup, clock or async pulse, settle (J/K hold), then respond.
module hc112_op_sched
  import hc112_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] op_a,
  input  logic [2:0] op_b,
  input  logic       ch_a,
  input  logic       ch_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rsp_valid,
  output logic       rsp_src,
  output logic       rsp_q,
  output logic       rsp_err,
  output logic       busy,
  output logic [1:0] ff_j,
  output logic [1:0] ff_k,
  output logic [1:0] ff_clk,
  output logic [1:0] ff_sd_n,
  output logic [1:0] ff_rd_n,
  input  logic [1:0] ff_q
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);

  state_e     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_op;
  logic       r_ch, r_src;
  logic       r_gnt_a, r_gnt_b, r_rsp_valid, r_rsp_src, r_rsp_q, r_rsp_err, r_busy;
  logic [1:0] r_j, r_k, r_clk, r_sd_n, r_rd_n;

  logic       w_gnt_a, w_gnt_b;
  logic [2:0] w_op;
  logic       w_ch;
  logic [1:0] w_jk;

  hc112_rr_arb u_arb (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_en    (r_state == ST_IDLE),
    .i_req_a (req_a),
    .i_req_b (req_b),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign w_op = w_gnt_b ? op_b : op_a;
  assign w_ch = w_gnt_b ? ch_b : ch_a;
  assign w_jk = op_to_jk(w_op);

  // Operation sequencer; every output is a register set here
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_ch        <= 1'b0;
      r_src       <= 1'b0;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_src   <= 1'b0;
      r_rsp_q     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_j         <= '0;
      r_k         <= '0;
      r_clk       <= '0;
      r_sd_n      <= 2'b11;
      r_rd_n      <= 2'b11;
    end else begin
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_gnt_a | w_gnt_b) begin
          r_state    <= ST_SETUP;
          r_cnt      <= '0;
          r_busy     <= 1'b1;
          r_gnt_a    <= w_gnt_a;
          r_gnt_b    <= w_gnt_b;
          r_op       <= w_op;
          r_ch       <= w_ch;
          r_src      <= w_gnt_b;
          r_j[w_ch]  <= w_jk[1];
          r_k[w_ch]  <= w_jk[0];
        end
        ST_SETUP: begin
          if (!op_legal(r_op)) begin
            // illegal code: respond with error, pins never leave idle
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_src   <= r_src;
            r_rsp_q     <= 1'b0;
            r_rsp_err   <= 1'b1;
          end else if (r_cnt == SETUP_LAST) begin
            r_state <= ST_PULSE;
            r_cnt   <= '0;
            case (r_op)
              OP_APRESET: r_sd_n[r_ch] <= 1'b0;
              OP_ACLEAR:  r_rd_n[r_ch] <= 1'b0;
              default:    r_clk[r_ch]  <= 1'b1;
            endcase
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_PULSE: begin
          if (r_cnt == PULSE_LAST) begin
            // falling clk here is the flip-flop's active edge; J/K stay put
            r_state <= ST_SETTLE;
            r_clk   <= '0;
            r_sd_n  <= 2'b11;
            r_rd_n  <= 2'b11;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_SETTLE: begin
          r_state     <= ST_DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_src   <= r_src;
          r_rsp_q     <= ff_q[r_ch];
          r_rsp_err   <= 1'b0;
          r_j         <= '0;
          r_k         <= '0;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_a     = r_gnt_a;
  assign gnt_b     = r_gnt_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_src   = r_rsp_src;
  assign rsp_q     = r_rsp_q;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign ff_j      = r_j;
  assign ff_k      = r_k;
  assign ff_clk    = r_clk;
  assign ff_sd_n   = r_sd_n;
  assign ff_rd_n   = r_rd_n;

endmodule

// File: tb/tb_hc112_op_sched.sv
// Bench for hc112_op_sched: behavioural dual JK flip-flop on the pins,
// directed vector table, arbitration, randomized ops, reset mid-op.
module tb_hc112_op_sched;

  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 1;

  logic       Clk = 1'b0, Rst_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] op_a = 3'd0, op_b = 3'd0;
  logic       ch_a = 1'b0, ch_b = 1'b0;
  logic       gnt_a, gnt_b, rsp_valid, rsp_src, rsp_q, rsp_err, busy;
  logic [1:0] ff_j, ff_k, ff_clk, ff_sd_n, ff_rd_n;
  logic [1:0] ffq  = 2'b00;
  logic [1:0] pclk = 2'b00;

  always #5 Clk = ~Clk;

  hc112_op_sched #(.SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b), .ch_a(ch_a), .ch_b(ch_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rsp_valid(rsp_valid), .rsp_src(rsp_src),
    .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy),
    .ff_j(ff_j), .ff_k(ff_k), .ff_clk(ff_clk), .ff_sd_n(ff_sd_n), .ff_rd_n(ff_rd_n),
    .ff_q(ffq)
  );

  // 74HC112-style device: async SD/RD dominate, else act on clk falling edge
  always @(ff_clk or ff_sd_n or ff_rd_n) begin
    for (int c = 0; c < 2; c++) begin
      if (!ff_sd_n[c])                ffq[c] = 1'b1;
      else if (!ff_rd_n[c])           ffq[c] = 1'b0;
      else if (pclk[c] && !ff_clk[c]) ffq[c] = ff_j[c] ? (ff_k[c] ? ~ffq[c] : 1'b1)
                                                       : (ff_k[c] ? 1'b0 : ffq[c]);
    end
    pclk = ff_clk;
  end

  int n_chk = 0, n_fail = 0;
  logic [1:0] m_q = 2'b00;   // reference flip-flop state per channel
  logic       m_last = 1'b1; // reference round-robin pointer

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic next_q(input logic [2:0] op, input logic q);
    case (op)
      3'd0: return q;
      3'd1: return 1'b0;
      3'd2: return 1'b1;
      3'd3: return ~q;
      3'd4: return 1'b1;
      3'd5: return 1'b0;
      default: return q;
    endcase
  endfunction

  // Waits for a grant and follows the op to its response, counting pin activity
  task automatic run_txn(input logic exp_src, input logic [2:0] op, input logic ch,
                         input logic exp_q, input logic exp_err, input logic drop);
    int k, jc, kc, cc, sc, rc;
    bit legal, other_bad, both_low, gnt_extra, busy_bad;
    logic oc;
    oc = ~ch;
    legal = (op <= 3'd5);
    k = 0;
    while (k < 20 && !(gnt_a | gnt_b)) begin @(negedge Clk); k++; end
    if (!(gnt_a | gnt_b)) begin chk("gnt_timeout", 0, 1); return; end
    chk("gnt_src", int'({gnt_b, gnt_a}), exp_src ? 2 : 1);
    if (drop) begin if (gnt_b) req_b = 1'b0; else req_a = 1'b0; end
    k = 1; jc = 0; kc = 0; cc = 0; sc = 0; rc = 0;
    other_bad = 0; both_low = 0; gnt_extra = 0; busy_bad = 0;
    while (1) begin
      if (ff_j[ch])     jc++;
      if (ff_k[ch])     kc++;
      if (ff_clk[ch])   cc++;
      if (!ff_sd_n[ch]) sc++;
      if (!ff_rd_n[ch]) rc++;
      if ({ff_j[oc], ff_k[oc], ff_clk[oc], ff_sd_n[oc], ff_rd_n[oc]} != 5'b00011) other_bad = 1;
      if ((~ff_sd_n & ~ff_rd_n) != 2'b00) both_low = 1;
      if (k > 1 && (gnt_a | gnt_b)) gnt_extra = 1;
      if (!busy) busy_bad = 1;
      if (rsp_valid || k >= 30) break;
      @(negedge Clk); k++;
    end
    chk("latency", k, legal ? SETUP_CYC + PULSE_CYC + 2 : 2);
    chk("j_cycles", jc, (legal && (op == 3'd2 || op == 3'd3)) ? SETUP_CYC + PULSE_CYC + 1 : 0);
    chk("k_cycles", kc, (legal && (op == 3'd1 || op == 3'd3)) ? SETUP_CYC + PULSE_CYC + 1 : 0);
    chk("clk_cycles", cc, (op <= 3'd3) ? PULSE_CYC : 0);
    chk("sd_low_cycles", sc, (op == 3'd4) ? PULSE_CYC : 0);
    chk("rd_low_cycles", rc, (op == 3'd5) ? PULSE_CYC : 0);
    chk("other_ch_idle", int'(other_bad), 0);
    chk("sd_rd_both_low", int'(both_low), 0);
    chk("gnt_one_cycle", int'(gnt_extra), 0);
    chk("busy_in_op", int'(busy_bad), 0);
    chk("rsp_src", int'(rsp_src), int'(exp_src));
    chk("rsp_err", int'(rsp_err), int'(exp_err));
    if (!exp_err) chk("rsp_q", int'(rsp_q), int'(exp_q));
    @(negedge Clk);
    chk("rsp_one_cycle", int'(rsp_valid), 0);
    chk("busy_idle", int'(busy), 0);
    m_last = exp_src;
  endtask

  typedef struct {
    logic       src;
    logic [2:0] op;
    logic       ch;
    logic       exp_q;
    logic       exp_err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       src, ch, e_q;
    logic [2:0] op;
    int         mode, k;

    tbl[0]  = '{1'b0, 3'd5, 1'b0, 1'b0, 1'b0}; // ACLEAR ch0
    tbl[1]  = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b0}; // ACLEAR ch1
    tbl[2]  = '{1'b0, 3'd2, 1'b0, 1'b1, 1'b0}; // SET ch0
    tbl[3]  = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0}; // TOGGLE ch1 x3
    tbl[4]  = '{1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'd5, 1'b0, 1'b0, 1'b0}; // ACLEAR ch0
    tbl[7]  = '{1'b0, 3'd4, 1'b0, 1'b1, 1'b0}; // APRESET ch0
    tbl[8]  = '{1'b0, 3'd7, 1'b0, 1'b0, 1'b1}; // illegal
    tbl[9]  = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0}; // RESET ch1
    tbl[10] = '{1'b1, 3'd0, 1'b1, 1'b0, 1'b0}; // HOLD ch1
    tbl[11] = '{1'b0, 3'd6, 1'b1, 1'b0, 1'b1}; // illegal

    // reset state
    repeat (2) @(negedge Clk);
    chk("rst_jkclk", int'({ff_j, ff_k, ff_clk}), 0);
    chk("rst_sd_n", int'(ff_sd_n), 3);
    chk("rst_rd_n", int'(ff_rd_n), 3);
    chk("rst_busy_gnt_rsp", int'({busy, gnt_a, gnt_b, rsp_valid}), 0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("post_rst_idle", int'({busy, ff_j, ff_k, ff_clk, ff_sd_n, ff_rd_n}), 6'b001111);

    // directed table
    foreach (tbl[i]) begin
      if (tbl[i].src) begin req_b = 1'b1; op_b = tbl[i].op; ch_b = tbl[i].ch; end
      else            begin req_a = 1'b1; op_a = tbl[i].op; ch_a = tbl[i].ch; end
      run_txn(tbl[i].src, tbl[i].op, tbl[i].ch, tbl[i].exp_q, tbl[i].exp_err, 1'b1);
      if (!tbl[i].exp_err) m_q[tbl[i].ch] = next_q(tbl[i].op, m_q[tbl[i].ch]);
      req_a = 1'b0; req_b = 1'b0;
    end

    // arbitration: both held, HOLD ops, grants must alternate
    req_a = 1'b1; op_a = 3'd0; ch_a = 1'b0;
    req_b = 1'b1; op_b = 3'd0; ch_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src = ~m_last;
      run_txn(src, 3'd0, src, m_q[src], 1'b0, 1'b0);
    end
    req_a = 1'b0; req_b = 1'b0;

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      op_a = 3'($urandom_range(0, 7)); ch_a = 1'($urandom_range(0, 1));
      op_b = 3'($urandom_range(0, 7)); ch_b = 1'($urandom_range(0, 1));
      req_a = (mode != 1);
      req_b = (mode != 0);
      src = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ~m_last;
      op  = src ? op_b : op_a;
      ch  = src ? ch_b : ch_a;
      e_q = next_q(op, m_q[ch]);
      run_txn(src, op, ch, e_q, (op > 3'd5), 1'b1);
      if (op <= 3'd5) m_q[ch] = e_q;
      req_a = 1'b0; req_b = 1'b0;
    end

    // reset during the clock pulse of a TOGGLE
    req_a = 1'b1; op_a = 3'd3; ch_a = 1'b0;
    k = 0;
    while (k < 20 && !gnt_a) begin @(negedge Clk); k++; end
    chk("midrst_gnt", int'(gnt_a), 1);
    req_a = 1'b0;
    @(negedge Clk);
    chk("midrst_in_pulse", int'(ff_clk[0]), 1);
    Rst_n = 1'b0;
    #1;
    chk("midrst_pins_idle", int'({ff_j, ff_k, ff_clk, ff_sd_n, ff_rd_n}), 10'b0000001111);
    chk("midrst_busy", int'(busy), 0);
    k = 0;
    repeat (3) begin @(negedge Clk); if (rsp_valid) k++; end
    Rst_n = 1'b1;
    repeat (2) begin @(negedge Clk); if (rsp_valid) k++; end
    chk("midrst_no_rsp", k, 0);
    m_last = 1'b1;

    // after reset: tie goes to A, then pending B is served
    req_a = 1'b1; op_a = 3'd5; ch_a = 1'b0;
    req_b = 1'b1; op_b = 3'd2; ch_b = 1'b1;
    run_txn(1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    m_q[0] = 1'b0;
    run_txn(1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    m_q[1] = 1'b1;
    req_a = 1'b0; req_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hc112_op_sched.md
Name: hc112_op_sched

Overview:
- Scheduler that shares one dual negative-edge JK flip-flop unit (two channels, each with J, K, Clk, active-low SD and RD) between two requesters, A and B.
- Each request names a channel and an operation. The block arbitrates round-robin, sequences the flip-flop pins (data setup, clock or async pulse, settle), samples Q and returns it with a one-cycle response strobe.
- Sits between system-side command sources and the flip-flop pins; it is the only driver of those pins.

Parameters:
- SETUP_CYC, 1, cycles J/K are held stable before the clock pulse (>=1).
- PULSE_CYC, 1, cycles ff_clk is high, or SD_n/RD_n is low, during the pulse (>=1).

Ports:
- Clk  in  1  system clock; all logic on its rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- req_a / req_b  in  1  request valid; held until gnt seen.
- op_a / op_b  in  3  operation: 0 HOLD, 1 RESET (J0K1), 2 SET (J1K0), 3 TOGGLE (J1K1), 4 APRESET (SD_n pulse), 5 ACLEAR (RD_n pulse), 6-7 illegal.
- ch_a / ch_b  in  1  target channel: 0 = FF1, 1 = FF2.
- gnt_a / gnt_b  out  1  one-cycle accept pulse.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_src  out  1  requester served: 0 = A, 1 = B.
- rsp_q  out  1  sampled Q of the target channel.
- rsp_err  out  1  illegal op code.
- busy  out  1  high whenever state != IDLE.
- ff_j, ff_k, ff_clk, ff_sd_n, ff_rd_n  out  2 each  per-channel flip-flop pins; bit0 = FF1, bit1 = FF2.
- ff_q  in  2  flip-flop Q outputs.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0 except ff_sd_n = 2'b11 and ff_rd_n = 2'b11; rr_last = B, so A wins the first tie.
- Idle pin values: J = K = 0, clk = 0, SD_n = RD_n = 1 on both channels.
- A non-target channel's pins always stay at idle values.
- All outputs are registered.

FSM: IDLE -> SETUP -> PULSE -> SETTLE -> DONE -> IDLE.
- IDLE:
  - Any req: latch op, ch and src, and go to SETUP.
  - Both req: grant the one that is not rr_last; rr_last is updated at grant.
  - Unselected requester keeps its req high and waits.
- SETUP, SETUP_CYC cycles:
  - gnt_x pulses in the first SETUP cycle.
  - Drive J/K of the target channel per op. Async ops and HOLD drive J = K = 0.
  - Illegal op: skip to DONE with rsp_err = 1 and no pin activity.
- PULSE, PULSE_CYC cycles:
  - Ops 0-3: ff_clk[ch] = 1. The falling edge at PULSE exit is the flip-flop's active edge.
  - Op 4: ff_sd_n[ch] = 0. Op 5: ff_rd_n[ch] = 0.
  - J/K stay stable throughout PULSE.
- SETTLE, 1 cycle: pins back to idle except J/K, which are held one more cycle as hold time. rsp_q is captured from ff_q[ch] at the end of this cycle.
- DONE, 1 cycle: rsp_valid = 1 with rsp_src, rsp_q and rsp_err; J/K return to idle.
- DONE -> IDLE: a pending req may be granted on the next edge.
- Latency with defaults: grant edge to rsp_valid = 4 cycles (SETUP, PULSE, SETTLE, DONE). General: SETUP_CYC + PULSE_CYC + 2.
- Throughput: one op per SETUP_CYC + PULSE_CYC + 3 cycles.
- Requests are ignored while busy; req changes while not granted are allowed.
- Reset mid-operation: pins return to idle immediately; the in-flight op is dropped with no rsp_valid; the flip-flop state is whatever the partial pulse produced.
- Never asserts SD_n and RD_n low together; never pulses clk and an async pin in the same op.

Decomposition:
- Shared package hc112_pkg:
  - op enum (HOLD, RESET, SET, TOGGLE, APRESET, ACLEAR).
  - FSM state enum.
  - Function op_to_jk(op) returning {J,K}.
- One sub-module, hc112_rr_arb: two-requester round-robin arbiter holding rr_last, with an enable input taken from IDLE.

Test Plan:
- Reset: after Rst_n = 0 -> 1 with no req, check ff_sd_n = ff_rd_n = 2'b11, ff_j = ff_k = ff_clk = 0, busy = 0.
- Single op: req_a, op 2 (SET), ch 0, flip-flop model initially Q = 0 -> gnt_a 1 cycle after req; ff_j[0] = 1 for 3 cycles; ff_clk[0] high 1 cycle; rsp_valid 4 cycles after gnt with rsp_q = 1, rsp_src = 0.
- Toggle chain: req_b, op 3, ch 1, three times from Q = 0 -> rsp_q sequence 1, 0, 1; channel 0 pins idle throughout.
- Arbitration: req_a and req_b both held, each op 0 -> grants A, B, A, B alternating; each response matches its rsp_src.
- Async ops and illegal code:
  - op 5, ch 0 -> ff_rd_n[0] low exactly PULSE_CYC cycles with clk idle; rsp_q = 0.
  - op 4 -> ff_sd_n low; rsp_q = 1.
  - op 7 -> rsp_err = 1, no pin toggles.
- Reset mid-op: drop Rst_n during PULSE of a TOGGLE -> all pins idle in the same cycle; no rsp_valid; a new req after reset is granted normally.
